pipe_skid_stage: RTL and testbench

//  Parametrised pipeline stage register: next generation of the fixed-width inter-stage latches (ID/EX, EX/MEM, MEM/WB).
//  - Carries a WIDTH-bit stage bundle with a valid/ready handshake and a 2-entry skid buffer.
//  - Downstream back-pressure (stall) stalls the stage without a combinational ready path.
//  - Synchronous flush squashes in-flight beats on branch/exception.
//  - Saturating stall counter for performance debug.

---
 rtl/pipe_skid_stage.sv | 134 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage
//   Generic pipeline stage register carrying a WIDTH-bit bundle across a
//   valid/ready handshake, with a two-entry skid (main + skid register) so
//   that in_ready is a flop and never depends combinationally on out_ready.
//   A synchronous flush squashes every held beat and any beat offered in the
//   same cycle. A saturating counter tracks stalled output cycles.
//
//   state     | meaning
//   ----------+----------------------------------------------
//   ST_EMPTY  | no beat held, out_valid=0
//   ST_ONE    | main register holds the head beat
//   ST_TWO    | main holds head, skid holds the next beat
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   in_valid     upstream beat present
//   in_ready     stage can accept a beat (registered)
//   in_bundle    upstream bundle
//   out_valid    beat present at output
//   out_ready    downstream accepts beat
//   out_bundle   head bundle (main register)
//   flush        synchronous squash of held beats and this cycle's input
//   occupancy    beats held (0..2)
//   stall_count  saturating count of cycles with out_valid & !out_ready
module pipe_skid_stage #(
  parameter int               WIDTH       = 71,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bundle,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bundle,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_main;
  logic [WIDTH-1:0]   r_skid;
  logic [WIDTH-1:0]   w_main_nxt;
  logic [WIDTH-1:0]   w_skid_nxt;
  logic               r_in_ready;
  logic [CNT_W-1:0]   r_stall_count;
  logic               w_accept;
  logic               w_send;
  logic               w_stall;

  assign out_valid   = (r_state != ST_EMPTY);
  assign out_bundle  = r_main;
  assign occupancy   = r_state;
  assign in_ready    = r_in_ready;
  assign stall_count = r_stall_count;

  assign w_accept = in_valid & r_in_ready;
  assign w_send   = out_valid & out_ready;
  assign w_stall  = out_valid & ~out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      // A send this cycle has already been seen downstream; everything else
      // still held, plus any beat accepted now, is discarded.
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = RESET_VALUE;
      w_skid_nxt  = RESET_VALUE;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = in_bundle;
          end
        end
        ST_ONE: begin
          if (w_accept && w_send) begin
            w_main_nxt = in_bundle;
          end else if (w_accept) begin
            w_state_nxt = ST_TWO;
            w_skid_nxt  = in_bundle;
          end else if (w_send) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so no accept can occur.
          if (w_send) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_EMPTY;
      r_main        <= RESET_VALUE;
      r_skid        <= RESET_VALUE;
      r_in_ready    <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      // Registered ready looks at the next state only, so out_ready has no
      // combinational path to in_ready.
      r_in_ready <= (w_state_nxt != ST_TWO);
      if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

  localparam int W = 71;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_bundle;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_bundle;
  logic          flush;
  logic [1:0]    occupancy;
  logic [15:0]   stall_count;

  logic          s_in_valid;
  logic          s_in_ready;
  logic [7:0]    s_in_bundle;
  logic          s_out_valid;
  logic          s_out_ready;
  logic [7:0]    s_out_bundle;
  logic          s_flush;
  logic [1:0]    s_occupancy;
  logic [3:0]    s_stall_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  m_q[$];
  logic [W-1:0]  m_head;
  logic          m_rdy;
  logic [15:0]   m_stall;
  int            m_acc_cnt;
  int            obs_send_cnt;

  always #5 clk = ~clk;

  pipe_skid_stage #(.WIDTH(W), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_bundle(in_bundle),
    .out_valid(out_valid), .out_ready(out_ready), .out_bundle(out_bundle),
    .flush(flush), .occupancy(occupancy), .stall_count(stall_count)
  );

  pipe_skid_stage #(.WIDTH(8), .CNT_W(4)) u_dut_sat (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_bundle(s_in_bundle),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_bundle(s_out_bundle),
    .flush(s_flush), .occupancy(s_occupancy), .stall_count(s_stall_count)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // One clock edge on the main DUT with a reference model advanced in step;
  // all outputs are compared at edge+1.
  task automatic step();
    logic acc;
    logic snd;
    acc = in_valid & m_rdy;
    snd = (m_q.size() != 0) & out_ready;
    if (out_valid && out_ready && reset) obs_send_cnt++;
    @(posedge clk);
    if (!reset) begin
      m_q.delete();
      m_head  = '0;
      m_rdy   = 1'b0;
      m_stall = '0;
    end else begin
      if (m_q.size() != 0 && !out_ready && m_stall != 16'hFFFF) m_stall++;
      if (snd) void'(m_q.pop_front());
      if (flush) begin
        m_q.delete();
        m_head = '0;
      end else if (acc) begin
        m_q.push_back(in_bundle);
        m_acc_cnt++;
      end
      if (m_q.size() != 0) m_head = m_q[0];
      m_rdy = (m_q.size() != 2);
    end
    #1;
    chk("m_occ",   {69'd0, occupancy},   W'(m_q.size()));
    chk("m_valid", {70'd0, out_valid},   {70'd0, m_q.size() != 0});
    chk("m_data",  out_bundle,           m_head);
    chk("m_ready", {70'd0, in_ready},    {70'd0, m_rdy});
    chk("m_stall", {55'd0, stall_count}, {55'd0, m_stall});
  endtask

  initial begin
    logic [W-1:0] ones;
    ones = '1;
    m_head = '0; m_rdy = 1'b0; m_stall = '0; m_acc_cnt = 0; obs_send_cnt = 0;
    reset = 1'b0; in_valid = 1'b1; in_bundle = 71'h7F; out_ready = 1'b1; flush = 1'b0;
    s_in_valid = 1'b0; s_in_bundle = 8'h00; s_out_ready = 1'b1; s_flush = 1'b0;

    // Reset with in_valid high
    #2;
    chk("rst_valid", {70'd0, out_valid}, 71'd0);
    chk("rst_occ",   {69'd0, occupancy}, 71'd0);
    chk("rst_data",  out_bundle,         71'd0);
    chk("rst_ready", {70'd0, in_ready},  71'd0);
    step(); step();
    reset = 1'b1; in_valid = 1'b0;
    step();
    chk("rel_ready", {70'd0, in_ready}, 71'd1);

    // Streaming
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1; in_bundle = W'(k);
      step();
      chk("str_data", out_bundle,         W'(k));
      chk("str_occ",  {69'd0, occupancy}, 71'd1);
    end
    in_valid = 1'b0;
    step();
    chk("str_drain", {69'd0, occupancy},   71'd0);
    chk("str_stall", {55'd0, stall_count}, 71'd0);

    // Back-pressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_bundle = 71'hA; step();
    in_bundle = 71'hB; step();
    in_valid = 1'b0; step();
    chk("bp_occ",   {69'd0, occupancy}, 71'd2);
    chk("bp_ready", {70'd0, in_ready},  71'd0);
    chk("bp_head",  out_bundle,         71'hA);
    out_ready = 1'b1; step();
    chk("bp_second", out_bundle,         71'hB);
    chk("bp_occ1",   {69'd0, occupancy}, 71'd1);
    step();
    chk("bp_empty", {69'd0, occupancy},   71'd0);
    chk("bp_stall", {55'd0, stall_count}, 71'd2);

    // Flush with a full stage and a beat offered in the same cycle
    out_ready = 1'b0;
    in_valid = 1'b1; in_bundle = 71'hD; step();
    in_bundle = 71'hE; step();
    chk("fl_full", {69'd0, occupancy}, 71'd2);
    in_bundle = 71'hC; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_occ",   {69'd0, occupancy},   71'd0);
    chk("fl_valid", {70'd0, out_valid},   71'd0);
    chk("fl_ready", {70'd0, in_ready},    71'd1);
    chk("fl_data",  out_bundle,           71'd0);
    chk("fl_stall", {55'd0, stall_count}, 71'd4);
    out_ready = 1'b1;
    step(); step();
    chk("fl_no_c", {69'd0, occupancy}, 71'd0);

    // Alternating patterns with toggling out_ready
    m_acc_cnt = 0; obs_send_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid  = 1'b1;
      in_bundle = (i % 2 == 0) ? ones : '0;
      out_ready = (i % 2 == 1);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("alt_count", W'(obs_send_cnt), W'(m_acc_cnt));
    chk("alt_empty", {69'd0, occupancy}, 71'd0);

    // Saturation on the narrow-counter instance
    s_in_valid = 1'b1; s_in_bundle = 8'h5A; s_out_ready = 1'b0;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    chk("sat_occ", {69'd0, s_occupancy}, 71'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 13) chk("sat_14", {67'd0, s_stall_count}, 71'd14);
    end
    chk("sat_stall", {67'd0, s_stall_count}, 71'd15);
    chk("sat_data",  {63'd0, s_out_bundle},  71'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
